// File: rtl/prog_mem_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_host_arbiter
// Purpose  : Shares the single-port program memory between core fetch and a host command port.
// Revision : 1.0
// ============================================================================
module prog_mem_host_arbiter #(
    parameter int PC_WIDTH     = 9,
    parameter int INST_WIDTH   = 12,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   core_pc,
    input  logic                  core_fetch_boundary,
    output logic [INST_WIDTH-1:0] core_inst,
    output logic                  core_halt,
    output logic                  halted,
    output logic                  halt_timeout,
    input  logic                  host_cmd_valid,
    output logic                  host_cmd_ready,
    input  logic [1:0]            host_cmd_op,
    input  logic [INST_WIDTH-1:0] host_cmd_data,
    output logic                  host_rsp_valid,
    input  logic                  host_rsp_ready,
    output logic [INST_WIDTH-1:0] host_rsp_data,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic                  mem_we,
    output logic [INST_WIDTH-1:0] mem_wdata,
    input  logic [INST_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] c_RUN       = 3'd0;
    localparam logic [2:0] c_HALT_WAIT = 3'd1;
    localparam logic [2:0] c_IDLE      = 3'd2;
    localparam logic [2:0] c_WRITE     = 3'd3;
    localparam logic [2:0] c_READ      = 3'd4;
    localparam logic [2:0] c_RSP       = 3'd5;

    localparam logic [1:0] c_OP_SET_ADDR = 2'b00;
    localparam logic [1:0] c_OP_WRITE    = 2'b01;
    localparam logic [1:0] c_OP_READ     = 2'b10;
    localparam logic [1:0] c_OP_RESUME   = 2'b11;

    localparam int                 c_CNT_W    = $clog2(HALT_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HALT_TIMEOUT - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_nextState;
    logic [PC_WIDTH-1:0]   r_addrReg;
    logic [INST_WIDTH-1:0] r_wdata;
    logic [c_CNT_W-1:0]    r_timeoutCnt;
    logic                  r_haltTimeout;
    logic                  r_rspValid;
    logic [INST_WIDTH-1:0] r_rspData;
    logic                  w_cmdFire;
    logic                  w_cntExpired;
    logic                  w_rspFire;

    assign w_cmdFire    = host_cmd_valid && (r_state == c_IDLE);
    assign w_cntExpired = (r_timeoutCnt == c_CNT_LAST);
    assign w_rspFire    = (r_state == c_RSP) && host_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_RUN: begin
                if (host_cmd_valid) w_nextState = c_HALT_WAIT;
            end
            c_HALT_WAIT: begin
                if (core_fetch_boundary || w_cntExpired) w_nextState = c_IDLE;
            end
            c_IDLE: begin
                if (host_cmd_valid) begin
                    case (host_cmd_op)
                        c_OP_WRITE:  w_nextState = c_WRITE;
                        c_OP_READ:   w_nextState = c_READ;
                        c_OP_RESUME: w_nextState = c_RUN;
                        default:     w_nextState = c_IDLE;
                    endcase
                end
            end
            c_WRITE: w_nextState = c_IDLE;
            c_READ:  w_nextState = c_RSP;
            c_RSP: begin
                if (host_rsp_ready) w_nextState = c_IDLE;
            end
            default: w_nextState = c_RUN;
        endcase
    end

    // Host states keep addr_reg on the memory so the synchronous read is already in flight for READ.
    always_comb begin
        core_inst      = '0;
        core_halt      = 1'b0;
        halted         = 1'b0;
        host_cmd_ready = 1'b0;
        mem_addr       = r_addrReg;
        mem_we         = 1'b0;
        mem_wdata      = '0;
        case (r_state)
            c_RUN: begin
                mem_addr  = core_pc;
                core_inst = mem_rdata;
            end
            c_HALT_WAIT: begin
                mem_addr  = core_pc;
                core_inst = mem_rdata;
                core_halt = 1'b1;
            end
            c_IDLE: begin
                core_halt      = 1'b1;
                halted         = 1'b1;
                host_cmd_ready = 1'b1;
            end
            c_WRITE: begin
                core_halt = 1'b1;
                halted    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = r_wdata;
            end
            c_READ, c_RSP: begin
                core_halt = 1'b1;
                halted    = 1'b1;
            end
            default: begin
                core_halt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addrReg     <= '0;
            r_wdata       <= '0;
            r_timeoutCnt  <= '0;
            r_haltTimeout <= 1'b0;
            r_rspValid    <= 1'b0;
            r_rspData     <= '0;
        end else begin
            if ((r_state == c_HALT_WAIT) && (w_nextState == c_HALT_WAIT)) begin
                r_timeoutCnt <= r_timeoutCnt + 1'b1;
            end else begin
                r_timeoutCnt <= '0;
            end

            // A boundary in the expiry cycle counts as a clean halt.
            if ((r_state == c_HALT_WAIT) && !core_fetch_boundary && w_cntExpired) begin
                r_haltTimeout <= 1'b1;
            end else if (w_cmdFire && (host_cmd_op == c_OP_RESUME)) begin
                r_haltTimeout <= 1'b0;
            end

            if (w_cmdFire && (host_cmd_op == c_OP_SET_ADDR)) begin
                r_addrReg <= host_cmd_data[PC_WIDTH-1:0];
            end else if ((r_state == c_WRITE) || w_rspFire) begin
                r_addrReg <= r_addrReg + 1'b1;
            end

            if (w_cmdFire && (host_cmd_op == c_OP_WRITE)) begin
                r_wdata <= host_cmd_data;
            end

            if (r_state == c_READ) begin
                r_rspValid <= 1'b1;
                r_rspData  <= mem_rdata;
            end else if (w_rspFire) begin
                r_rspValid <= 1'b0;
            end
        end
    end

    assign halt_timeout   = r_haltTimeout;
    assign host_rsp_valid = r_rspValid;
    assign host_rsp_data  = r_rspData;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem_host_arbiter
// Purpose  : Scenario and randomized checks of prog_mem_host_arbiter against a word-level memory model.
// Revision : 1.0
// ============================================================================
module tb_prog_mem_host_arbiter;

    localparam int PC_WIDTH     = 9;
    localparam int INST_WIDTH   = 12;
    localparam int HALT_TIMEOUT = 255;

    localparam logic [1:0] OP_SET = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_RES = 2'b11;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [PC_WIDTH-1:0]   corePc = '0;
    logic                  coreFetchBoundary = 1'b0;
    logic [INST_WIDTH-1:0] coreInst;
    logic                  coreHalt;
    logic                  halted;
    logic                  haltTimeout;
    logic                  hostCmdValid = 1'b0;
    logic                  hostCmdReady;
    logic [1:0]            hostCmdOp = '0;
    logic [INST_WIDTH-1:0] hostCmdData = '0;
    logic                  hostRspValid;
    logic                  hostRspReady = 1'b0;
    logic [INST_WIDTH-1:0] hostRspData;
    logic [PC_WIDTH-1:0]   memAddr;
    logic                  memWe;
    logic [INST_WIDTH-1:0] memWdata;
    logic [INST_WIDTH-1:0] memRdata;
    logic                  memClear = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [INST_WIDTH-1:0] memArr [0:(1<<PC_WIDTH)-1];
    logic [INST_WIDTH-1:0] refMem [0:(1<<PC_WIDTH)-1];
    logic [PC_WIDTH-1:0]   refAddr = '0;

    always #5 clk = ~clk;

    prog_mem_host_arbiter #(
        .PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH), .HALT_TIMEOUT(HALT_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .core_pc(corePc), .core_fetch_boundary(coreFetchBoundary),
        .core_inst(coreInst), .core_halt(coreHalt), .halted(halted), .halt_timeout(haltTimeout),
        .host_cmd_valid(hostCmdValid), .host_cmd_ready(hostCmdReady),
        .host_cmd_op(hostCmdOp), .host_cmd_data(hostCmdData),
        .host_rsp_valid(hostRspValid), .host_rsp_ready(hostRspReady), .host_rsp_data(hostRspData),
        .mem_addr(memAddr), .mem_we(memWe), .mem_wdata(memWdata), .mem_rdata(memRdata)
    );

    // Synchronous single-port memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < (1<<PC_WIDTH); i++) memArr[i] <= '0;
            memRdata <= '0;
        end else begin
            if (memWe) memArr[memAddr] <= memWdata;
            memRdata <= memArr[memAddr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [INST_WIDTH-1:0] d);
        int n;
        n = 0;
        hostCmdValid = 1'b1;
        hostCmdOp    = op;
        hostCmdData  = d;
        #1;
        while (!hostCmdReady && n < 600) begin
            step();
            #1;
            n++;
        end
        checks++;
        if (!hostCmdReady) begin
            errors++;
            $display("FAIL cmd_accept: host_cmd_ready=%b after %0d cycles, required 1", hostCmdReady, n);
        end
        step();
        hostCmdValid = 1'b0;
    endtask

    task automatic doRead(input int delay, output logic [INST_WIDTH-1:0] d,
                          output bit stable, output bit gotValid, output bit cleared);
        int n;
        sendCmd(OP_RD, '0);
        n = 0;
        #1;
        while (!hostRspValid && n < 4) begin
            step();
            #1;
            n++;
        end
        gotValid = hostRspValid;
        d        = hostRspData;
        stable   = 1'b1;
        for (int k = 0; k < delay; k++) begin
            step();
            #1;
            if (!hostRspValid || hostRspData !== d) stable = 1'b0;
        end
        hostRspReady = 1'b1;
        step();
        hostRspReady = 1'b0;
        #1;
        cleared = !hostRspValid;
    endtask

    task automatic haltCore();
        hostCmdValid = 1'b1;
        hostCmdOp    = OP_SET;
        hostCmdData  = '0;
        step();
        step();
        coreFetchBoundary = 1'b1;
        step();
        coreFetchBoundary = 1'b0;
        sendCmd(OP_SET, '0);
        refAddr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        memClear = 1'b1;
        repeat (3) step();
        memClear = 1'b0;
        #1;
        checks++;
        if ({coreInst, coreHalt, halted, haltTimeout, hostCmdReady, hostRspValid, hostRspData,
             memAddr, memWe, memWdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: inst=%h halt=%b halted=%b to=%b rdy=%b rv=%b rd=%h addr=%h we=%b wd=%h, required all 0",
                     coreInst, coreHalt, halted, haltTimeout, hostCmdReady, hostRspValid, hostRspData,
                     memAddr, memWe, memWdata);
        end
        rst = 1'b0;
        step();
        corePc = 9'h0C4;
        #1;
        checks++;
        if (hostCmdReady !== 1'b0 || halted !== 1'b0 || coreHalt !== 1'b0 || memAddr !== 9'h0C4) begin
            errors++;
            $display("FAIL reset_run: rdy=%b halted=%b halt=%b addr=%h, required 0 0 0 0c4",
                     hostCmdReady, halted, coreHalt, memAddr);
        end
    endtask

    task automatic test_halt();
        corePc       = 9'h023;
        hostCmdValid = 1'b1;
        hostCmdOp    = OP_SET;
        hostCmdData  = 12'h010;
        #1;
        checks++;
        if (hostCmdReady !== 1'b0 || coreHalt !== 1'b0) begin
            errors++;
            $display("FAIL halt_run: rdy=%b halt=%b, required 0 0", hostCmdReady, coreHalt);
        end
        step();
        #1;
        checks++;
        if (coreHalt !== 1'b1 || halted !== 1'b0 || hostCmdReady !== 1'b0 || memAddr !== 9'h023) begin
            errors++;
            $display("FAIL halt_wait: halt=%b halted=%b rdy=%b addr=%h, required 1 0 0 023",
                     coreHalt, halted, hostCmdReady, memAddr);
        end
        repeat (4) step();
        coreFetchBoundary = 1'b1;
        step();
        coreFetchBoundary = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b1 || haltTimeout !== 1'b0 || hostCmdReady !== 1'b1 || coreInst !== 12'h000) begin
            errors++;
            $display("FAIL halt_idle: halted=%b to=%b rdy=%b inst=%h, required 1 0 1 000",
                     halted, haltTimeout, hostCmdReady, coreInst);
        end
        step();
        hostCmdValid = 1'b0;
        refAddr = 9'h010;
    endtask

    task automatic test_reset_write();
        sendCmd(OP_WR, 12'h0FF);
        #1;
        checks++;
        if (memWe !== 1'b1 || memAddr !== refAddr || memWdata !== 12'h0FF) begin
            errors++;
            $display("FAIL setaddr_write: we=%b addr=%h wd=%h, required 1 %h 0ff", memWe, memAddr, memWdata, refAddr);
        end
        refMem[refAddr] = 12'h0FF;
        refAddr = refAddr + 1'b1;
        corePc = '0;
        sendCmd(OP_WR, 12'h0AA);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (memWe !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_we: mem_we=%b, required 0", memWe);
        end
        step();
        #1;
        checks++;
        if (memArr[9'h011] !== refMem[9'h011]) begin
            errors++;
            $display("FAIL reset_abort_mem: mem[011]=%h, required %h", memArr[9'h011], refMem[9'h011]);
        end
        rst = 1'b0;
        step();
        #1;
        checks++;
        if ({coreInst, coreHalt, halted, haltTimeout, hostCmdReady, hostRspValid, memAddr, memWe, memWdata} !== '0) begin
            errors++;
            $display("FAIL reset_release: inst=%h halt=%b halted=%b to=%b rdy=%b rv=%b addr=%h we=%b wd=%h, required all 0",
                     coreInst, coreHalt, halted, haltTimeout, hostCmdReady, hostRspValid, memAddr, memWe, memWdata);
        end
    endtask

    task automatic test_load();
        logic [INST_WIDTH-1:0] vals [3];
        logic [PC_WIDTH-1:0]   addrs [3];
        vals  = '{12'hA5C, 12'h123, 12'h3C3};
        addrs = '{9'h1FF, 9'h000, 9'h001};
        haltCore();
        sendCmd(OP_SET, 12'hFFF);
        refAddr = 9'h1FF;
        for (int i = 0; i < 3; i++) begin
            sendCmd(OP_WR, vals[i]);
            #1;
            checks++;
            if (memWe !== 1'b1 || memAddr !== addrs[i] || memWdata !== vals[i]) begin
                errors++;
                $display("FAIL load_write%0d: we=%b addr=%h wd=%h, required 1 %h %h",
                         i, memWe, memAddr, memWdata, addrs[i], vals[i]);
            end
            refMem[refAddr] = vals[i];
            refAddr = refAddr + 1'b1;
            step();
            #1;
            checks++;
            if (memWe !== 1'b0 || hostCmdReady !== 1'b1) begin
                errors++;
                $display("FAIL load_idle%0d: we=%b rdy=%b, required 0 1", i, memWe, hostCmdReady);
            end
        end
    endtask

    task automatic test_readback();
        logic [INST_WIDTH-1:0] d;
        bit stable, gotValid, cleared;
        sendCmd(OP_SET, 12'h1FF);
        doRead(3, d, stable, gotValid, cleared);
        checks++;
        if (d !== 12'hA5C || !stable || !gotValid || !cleared) begin
            errors++;
            $display("FAIL readback_first: data=%h stable=%b valid=%b cleared=%b, required a5c 1 1 1",
                     d, stable, gotValid, cleared);
        end
        doRead(0, d, stable, gotValid, cleared);
        checks++;
        if (d !== 12'h123 || !gotValid || !cleared) begin
            errors++;
            $display("FAIL readback_next: data=%h valid=%b cleared=%b, required 123 1 1", d, gotValid, cleared);
        end
        refAddr = 9'h001;
    endtask

    task automatic test_random();
        logic [INST_WIDTH-1:0] d;
        logic [INST_WIDTH-1:0] got;
        bit stable, gotValid, cleared;
        int op;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            d  = INST_WIDTH'($urandom);
            if (op == 0) begin
                if ($urandom_range(0, 1) == 1) d[PC_WIDTH-1:0] = 9'h1FC + 9'($urandom_range(0, 7));
                sendCmd(OP_SET, d);
                refAddr = d[PC_WIDTH-1:0];
            end else if (op == 1) begin
                sendCmd(OP_WR, d);
                #1;
                checks++;
                if (memWe !== 1'b1 || memAddr !== refAddr || memWdata !== d) begin
                    errors++;
                    $display("FAIL rand_write%0d: we=%b addr=%h wd=%h, required 1 %h %h",
                             i, memWe, memAddr, memWdata, refAddr, d);
                end
                refMem[refAddr] = d;
                refAddr = refAddr + 1'b1;
            end else begin
                doRead(int'($urandom_range(0, 3)), got, stable, gotValid, cleared);
                checks++;
                if (got !== refMem[refAddr] || !stable || !gotValid || !cleared) begin
                    errors++;
                    $display("FAIL rand_read%0d: addr=%h data=%h stable=%b valid=%b cleared=%b, required %h 1 1 1",
                             i, refAddr, got, stable, gotValid, cleared, refMem[refAddr]);
                end
                refAddr = refAddr + 1'b1;
            end
        end
    endtask

    task automatic test_resume();
        sendCmd(OP_RES, '0);
        #1;
        checks++;
        if (coreHalt !== 1'b0 || halted !== 1'b0 || hostCmdReady !== 1'b0 || haltTimeout !== 1'b0) begin
            errors++;
            $display("FAIL resume: halt=%b halted=%b rdy=%b to=%b, required 0 0 0 0",
                     coreHalt, halted, hostCmdReady, haltTimeout);
        end
        for (int i = 0; i < 6; i++) begin
            corePc = (i == 0) ? 9'h1FF : PC_WIDTH'($urandom);
            #1;
            checks++;
            if (memAddr !== corePc || memWe !== 1'b0) begin
                errors++;
                $display("FAIL run_addr%0d: addr=%h we=%b, required %h 0", i, memAddr, memWe, corePc);
            end
            step();
            #1;
            checks++;
            if (coreInst !== refMem[corePc]) begin
                errors++;
                $display("FAIL run_fetch%0d: inst=%h, required %h", i, coreInst, refMem[corePc]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        hostCmdValid = 1'b1;
        hostCmdOp    = OP_SET;
        hostCmdData  = 12'h0AB;
        step();
        n = 0;
        #1;
        while (!halted && n < 400) begin
            step();
            n++;
            #1;
        end
        checks++;
        if (n != HALT_TIMEOUT || haltTimeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_force: cycles=%0d flag=%b, required %0d 1", n, haltTimeout, HALT_TIMEOUT);
        end
        step();
        hostCmdValid = 1'b0;
        sendCmd(OP_RES, '0);
        #1;
        checks++;
        if (haltTimeout !== 1'b0 || coreHalt !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: flag=%b halt=%b, required 0 0", haltTimeout, coreHalt);
        end
        hostCmdValid = 1'b1;
        hostCmdOp    = OP_SET;
        hostCmdData  = 12'h0AB;
        step();
        repeat (HALT_TIMEOUT - 1) step();
        coreFetchBoundary = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: halted=%b, required 0", halted);
        end
        step();
        coreFetchBoundary = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b1 || haltTimeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_tie: halted=%b flag=%b, required 1 0", halted, haltTimeout);
        end
        step();
        hostCmdValid = 1'b0;
        sendCmd(OP_RES, '0);
    endtask

    initial begin
        for (int i = 0; i < (1<<PC_WIDTH); i++) refMem[i] = '0;
        test_reset();
        test_halt();
        test_reset_write();
        test_load();
        test_readback();
        test_random();
        test_resume();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
